// File: rtl/thunderbird_pkg.sv
// Shared Thunderbird tail-light definitions: lamp pattern table, pattern classes, decoded modes.
package thunderbird_pkg;

    typedef enum logic [3:0] {
        CLS_OFF = 4'd0,
        CLS_L1  = 4'd1,
        CLS_L2  = 4'd2,
        CLS_L3  = 4'd3,
        CLS_R1  = 4'd4,
        CLS_R2  = 4'd5,
        CLS_R3  = 4'd6,
        CLS_HAZ = 4'd7,
        CLS_BAD = 4'd8
    } light_cls_t;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HAZ   = 2'b11
    } mode_t;

    // [5:3] = left cluster, [2:0] = right cluster
    localparam logic [5:0] PAT_OFF = 6'b000000;
    localparam logic [5:0] PAT_L1  = 6'b001000;
    localparam logic [5:0] PAT_L2  = 6'b011000;
    localparam logic [5:0] PAT_L3  = 6'b111000;
    localparam logic [5:0] PAT_R1  = 6'b000100;
    localparam logic [5:0] PAT_R2  = 6'b000110;
    localparam logic [5:0] PAT_R3  = 6'b000111;
    localparam logic [5:0] PAT_HAZ = 6'b111111;

endpackage

// File: rtl/thunderbird_pattern_classify.sv
// Combinational lamp-pattern classifier: maps the raw 6-bit pattern onto its light class.
module thunderbird_pattern_classify
    import thunderbird_pkg::*;
(
    input  logic [5:0] lights_i,
    output light_cls_t cls_o
);

    always_comb begin
        cls_o = CLS_BAD;
        unique case (lights_i)
            PAT_OFF: cls_o = CLS_OFF;
            PAT_L1:  cls_o = CLS_L1;
            PAT_L2:  cls_o = CLS_L2;
            PAT_L3:  cls_o = CLS_L3;
            PAT_R1:  cls_o = CLS_R1;
            PAT_R2:  cls_o = CLS_R2;
            PAT_R3:  cls_o = CLS_R3;
            PAT_HAZ: cls_o = CLS_HAZ;
            default: cls_o = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/thunderbird_light_decoder.sv
// Thunderbird tail-light receiver: decodes signalled intent from the lamp pattern, checks
// sweep legality on each step strobe, confirms directions and counts protocol errors.
module thunderbird_light_decoder
    import thunderbird_pkg::*;
#(
    parameter int unsigned CONFIRM_CYCLES = 1,
    parameter int unsigned IDLE_TICKS     = 4,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             tick,
    input  logic [5:0]       lights,
    output logic [1:0]       mode,
    output logic             mode_valid,
    output logic             cycle_done,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned SW_W   = $clog2(CONFIRM_CYCLES + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam logic [SW_W-1:0]   SW_MAX   = SW_W'(CONFIRM_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TICKS);

    light_cls_t       cls_c;
    light_cls_t       prev_q, prev_d;
    mode_t            mode_q, mode_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
    logic [SW_W-1:0]  sweep_q, sweep_d, sweep_inc;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic             legal_c;

    thunderbird_pattern_classify u_classify (
        .lights_i (lights),
        .cls_o    (cls_c)
    );

    function automatic logic is_left(input light_cls_t c);
        return (c == CLS_L1) || (c == CLS_L2) || (c == CLS_L3);
    endfunction

    function automatic logic is_right(input light_cls_t c);
        return (c == CLS_R1) || (c == CLS_R2) || (c == CLS_R3);
    endfunction

    // Holding a class or dropping to OFF is always fine; otherwise follow the sweep order,
    // and any non-hazard state may restart on L1/R1/HAZ.
    function automatic logic is_legal(input light_cls_t p, input light_cls_t c);
        logic entry;
        entry = (c == CLS_L1) || (c == CLS_R1) || (c == CLS_HAZ);
        if (c == CLS_BAD)                return 1'b0;
        if ((c == p) || (c == CLS_OFF))  return 1'b1;
        case (p)
            CLS_L1:  return entry || (c == CLS_L2);
            CLS_L2:  return entry || (c == CLS_L3);
            CLS_R1:  return entry || (c == CLS_R2);
            CLS_R2:  return entry || (c == CLS_R3);
            CLS_HAZ: return 1'b0;
            default: return entry;
        endcase
    endfunction

    assign legal_c   = is_legal(prev_q, cls_c);
    assign sweep_inc = (sweep_q == SW_MAX) ? sweep_q : sweep_q + SW_W'(1);

    always_comb begin
        prev_d   = prev_q;
        mode_d   = mode_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        sweep_d  = sweep_q;
        idle_d   = idle_q;
        if (tick) begin
            prev_d = cls_c;
            if (cls_c == CLS_OFF) begin
                idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
            end else begin
                idle_d = '0;
            end
            if (!legal_c) begin
                err_d    = 1'b1;
                errcnt_d = (errcnt_q == '1) ? errcnt_q : errcnt_q + ERR_W'(1);
                mode_d   = MODE_NONE;
                valid_d  = 1'b0;
                sweep_d  = '0;
            end else begin
                case (cls_c)
                    CLS_OFF: begin
                        if ((prev_q == CLS_L3) || (prev_q == CLS_R3)) begin
                            done_d  = 1'b1;
                            sweep_d = sweep_inc;
                            mode_d  = (prev_q == CLS_L3) ? MODE_LEFT : MODE_RIGHT;
                            valid_d = valid_q || (sweep_inc == SW_MAX);
                        end
                        // Idle threshold fires once, on the transition into saturation
                        if ((idle_q != IDLE_MAX) && (idle_d == IDLE_MAX)) begin
                            mode_d  = MODE_NONE;
                            valid_d = 1'b0;
                            sweep_d = '0;
                        end
                    end
                    CLS_L1: begin
                        if (is_right(prev_q) || (mode_q != MODE_LEFT)) begin
                            valid_d = 1'b0;
                            sweep_d = '0;
                        end
                        mode_d = MODE_LEFT;
                    end
                    CLS_R1: begin
                        if (is_left(prev_q) || (mode_q != MODE_RIGHT)) begin
                            valid_d = 1'b0;
                            sweep_d = '0;
                        end
                        mode_d = MODE_RIGHT;
                    end
                    CLS_HAZ: begin
                        mode_d  = MODE_HAZ;
                        valid_d = 1'b1;
                        sweep_d = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            prev_q   <= CLS_OFF;
            mode_q   <= MODE_NONE;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
            sweep_q  <= '0;
            idle_q   <= '0;
        end else begin
            prev_q   <= prev_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            sweep_q  <= sweep_d;
            idle_q   <= idle_d;
        end
    end

    assign mode       = mode_q;
    assign mode_valid = valid_q;
    assign cycle_done = done_q;
    assign seq_err    = err_q;
    assign err_count  = errcnt_q;

endmodule

// File: tb/tb_thunderbird_light_decoder.sv
// Directed bench for thunderbird_light_decoder: sweeps, direction changes, errors, idle, reset.
module tb_thunderbird_light_decoder;
    import thunderbird_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       tick;
    logic [5:0] lights;
    logic [1:0] mode;
    logic       mode_valid;
    logic       cycle_done;
    logic       seq_err;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] PAT_X = 6'b101010;

    thunderbird_light_decoder #(
        .CONFIRM_CYCLES (1),
        .IDLE_TICKS     (4),
        .ERR_W          (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .tick       (tick),
        .lights     (lights),
        .mode       (mode),
        .mode_valid (mode_valid),
        .cycle_done (cycle_done),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] m, input logic v,
                           input logic cd, input logic se, input logic [7:0] ec);
        chk({tag, ".mode"},  32'(mode),       32'(m));
        chk({tag, ".valid"}, 32'(mode_valid), 32'(v));
        chk({tag, ".done"},  32'(cycle_done), 32'(cd));
        chk({tag, ".serr"},  32'(seq_err),    32'(se));
        chk({tag, ".ecnt"},  32'(err_count),  32'(ec));
    endtask

    // One tick every 4 clocks; returns on the negedge right after the sampling edge
    task automatic step(input logic [5:0] p);
        repeat (3) @(negedge CLOCK_50);
        lights = p;
        tick   = 1'b1;
        @(negedge CLOCK_50);
        tick   = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        tick    = 1'b0;
        lights  = PAT_OFF;
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);

        // Left sweep confirms LEFT after one cycle
        step(PAT_OFF); chk_all("l.off",  2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_L1);  chk_all("l.l1",   2'b01, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_L2);  chk_all("l.l2",   2'b01, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_L3);  chk_all("l.l3",   2'b01, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_OFF); chk_all("l.end",  2'b01, 1'b1, 1'b1, 1'b0, 8'd0);
        @(negedge CLOCK_50);
        chk("l.done_pulse", 32'(cycle_done), 32'd0);

        // Right sweep with a hold, then override to left
        step(PAT_R1);  chk_all("r.r1",   2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_R2);  chk_all("r.r2",   2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_R2);  chk_all("r.r2h",  2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_R3);  chk_all("r.r3",   2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_OFF); chk_all("r.end",  2'b10, 1'b1, 1'b1, 1'b0, 8'd0);
        step(PAT_R1);  chk_all("r.r1b",  2'b10, 1'b1, 1'b0, 1'b0, 8'd0);
        step(PAT_R2);  chk_all("r.r2b",  2'b10, 1'b1, 1'b0, 1'b0, 8'd0);
        step(PAT_L1);  chk_all("r.tol",  2'b01, 1'b0, 1'b0, 1'b0, 8'd0);

        // Skipped step is an error; decoding resyncs afterwards
        step(PAT_L3);  chk_all("e.skip", 2'b00, 1'b0, 1'b0, 1'b1, 8'd1);
        step(PAT_OFF);
        chk("e.off.serr", 32'(seq_err),   32'd0);
        chk("e.off.ecnt", 32'(err_count), 32'd1);
        step(PAT_L1);
        chk("e.l1.mode",  32'(mode),      32'd1);
        chk("e.l1.serr",  32'(seq_err),   32'd0);
        chk("e.l1.ecnt",  32'(err_count), 32'd1);

        // Unknown pattern, hazard recovery, illegal exit from hazard
        step(PAT_X);   chk_all("b.bad",  2'b00, 1'b0, 1'b0, 1'b1, 8'd2);
        step(PAT_HAZ); chk_all("b.haz",  2'b11, 1'b1, 1'b0, 1'b0, 8'd2);
        step(PAT_L1);  chk_all("b.hl1",  2'b00, 1'b0, 1'b0, 1'b1, 8'd3);

        // Idle timeout: the sweep-ending OFF is the first of four
        step(PAT_OFF); chk_all("i.off0", 2'b00, 1'b0, 1'b0, 1'b0, 8'd3);
        step(PAT_L1);
        step(PAT_L2);
        step(PAT_L3);
        step(PAT_OFF); chk_all("i.off1", 2'b01, 1'b1, 1'b1, 1'b0, 8'd3);
        step(PAT_OFF); chk_all("i.off2", 2'b01, 1'b1, 1'b0, 1'b0, 8'd3);
        step(PAT_OFF); chk_all("i.off3", 2'b01, 1'b1, 1'b0, 1'b0, 8'd3);
        step(PAT_OFF); chk_all("i.off4", 2'b00, 1'b0, 1'b0, 1'b0, 8'd3);
        step(PAT_OFF); chk_all("i.off5", 2'b00, 1'b0, 1'b0, 1'b0, 8'd3);

        // Error counter saturation
        for (int i = 0; i < 300; i++) step(PAT_X);
        chk_all("s.sat", 2'b00, 1'b0, 1'b0, 1'b1, 8'd255);

        // Reset mid-sweep overrides a concurrent tick
        step(PAT_OFF);
        step(PAT_R1);
        step(PAT_R2);  chk_all("x.r2",   2'b10, 1'b0, 1'b0, 1'b0, 8'd255);
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        tick    = 1'b1;
        lights  = PAT_R3;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        tick    = 1'b0;
        chk_all("x.rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        step(PAT_R3);  chk_all("x.r3",   2'b00, 1'b0, 1'b0, 1'b1, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
